// File: rtl/pcpi_dispatch.sv
// Core-side PCPI dispatcher: registers one co-processor op, broadcasts it to the
// multiplier/divider, merges their responses and flags unclaimed ops as illegal.
module pcpi_dispatch #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ENABLE_MUL     = 1,
  parameter int ENABLE_DIV     = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_valid,
  input  logic [31:0] core_insn,
  input  logic [31:0] core_rs1,
  input  logic [31:0] core_rs2,
  output logic        core_ready,
  output logic        core_done,
  output logic        core_wr,
  output logic [31:0] core_rd,
  output logic        core_illegal,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        mul_wr,
  input  logic        mul_ready,
  input  logic        mul_wait,
  input  logic [31:0] mul_rd,
  input  logic        div_wr,
  input  logic        div_ready,
  input  logic        div_wait,
  input  logic [31:0] div_rd
);

  localparam logic       EN_MUL   = (ENABLE_MUL != 0);
  localparam logic       EN_DIV   = (ENABLE_DIV != 0);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        wr_q, wr_d;
  logic [31:0] rd_q, rd_d;
  logic        illegal_q, illegal_d;

  logic mul_rdy, div_rdy, any_ready, any_wait;

  assign mul_rdy   = EN_MUL & mul_ready;
  assign div_rdy   = EN_DIV & div_ready;
  assign any_ready = mul_rdy | div_rdy;
  assign any_wait  = (EN_MUL & mul_wait) | (EN_DIV & div_wait);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      insn_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      insn_q    <= insn_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    insn_d    = insn_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (core_valid) begin
          insn_d  = core_insn;
          rs1_d   = core_rs1;
          rs2_d   = core_rs2;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Ready beats both wait and timeout; mul beats div.
        if (any_ready) begin
          illegal_d = 1'b0;
          wr_d      = mul_rdy ? mul_wr : div_wr;
          rd_d      = mul_rdy ? mul_rd : div_rd;
          state_d   = ST_DONE;
        end else if (any_wait) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          illegal_d = 1'b1;
          wr_d      = 1'b0;
          rd_d      = '0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        wr_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_ready   = (state_q == ST_IDLE);
  assign pcpi_valid   = (state_q == ST_ISSUE);
  assign core_done    = (state_q == ST_DONE);
  assign core_wr      = wr_q;
  assign core_rd      = rd_q;
  assign core_illegal = illegal_q;
  assign pcpi_insn    = insn_q;
  assign pcpi_rs1     = rs1_q;
  assign pcpi_rs2     = rs2_q;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Bench for pcpi_dispatch: a main instance plus a divider-disabled instance whose
// div inputs are tied active; slave timing is scripted per op and checked against a cycle model.
module tb_pcpi_dispatch;

  localparam int T = 16;
  localparam logic [31:0] DIV_VAL = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        core_valid = 1'b0;
  logic [31:0] core_insn = '0, core_rs1 = '0, core_rs2 = '0;
  logic        mul_wr = 1'b0, mul_ready = 1'b0, mul_wait = 1'b0;
  logic [31:0] mul_rd = '0;
  logic        div_wr = 1'b0, div_ready = 1'b0, div_wait = 1'b0;
  logic [31:0] div_rd = '0;
  logic        nd_div_one = 1'b1;
  logic [31:0] nd_div_rd = 32'hBAD0BAD0;

  logic        o_ready [2];
  logic        o_done  [2];
  logic        o_wr    [2];
  logic [31:0] o_rd    [2];
  logic        o_ill   [2];
  logic        o_valid [2];
  logic [31:0] o_insn  [2];
  logic [31:0] o_rs1   [2];
  logic [31:0] o_rs2   [2];

  int passed = 0;
  int total  = 0;
  logic [31:0] prev_rd = '0;

  always #5 clk = ~clk;

  pcpi_dispatch #(.TIMEOUT_CYCLES(T), .ENABLE_MUL(1), .ENABLE_DIV(1)) dut (
    .clk(clk), .resetn(resetn), .core_valid(core_valid), .core_insn(core_insn),
    .core_rs1(core_rs1), .core_rs2(core_rs2), .core_ready(o_ready[0]),
    .core_done(o_done[0]), .core_wr(o_wr[0]), .core_rd(o_rd[0]),
    .core_illegal(o_ill[0]), .pcpi_valid(o_valid[0]), .pcpi_insn(o_insn[0]),
    .pcpi_rs1(o_rs1[0]), .pcpi_rs2(o_rs2[0]), .mul_wr(mul_wr),
    .mul_ready(mul_ready), .mul_wait(mul_wait), .mul_rd(mul_rd), .div_wr(div_wr),
    .div_ready(div_ready), .div_wait(div_wait), .div_rd(div_rd)
  );

  pcpi_dispatch #(.TIMEOUT_CYCLES(T), .ENABLE_MUL(1), .ENABLE_DIV(0)) dut_nodiv (
    .clk(clk), .resetn(resetn), .core_valid(core_valid), .core_insn(core_insn),
    .core_rs1(core_rs1), .core_rs2(core_rs2), .core_ready(o_ready[1]),
    .core_done(o_done[1]), .core_wr(o_wr[1]), .core_rd(o_rd[1]),
    .core_illegal(o_ill[1]), .pcpi_valid(o_valid[1]), .pcpi_insn(o_insn[1]),
    .pcpi_rs1(o_rs1[1]), .pcpi_rs2(o_rs2[1]), .mul_wr(mul_wr),
    .mul_ready(mul_ready), .mul_wait(mul_wait), .mul_rd(mul_rd), .div_wr(nd_div_one),
    .div_ready(nd_div_one), .div_wait(nd_div_one), .div_rd(nd_div_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // mode: 0 = mul slave answers, 1 = div slave answers, 2 = both answer together.
  // The responding slave holds wait for cycles 1..wcnt of pcpi_valid and raises
  // ready in cycle lat (0 = never). hold keeps core_valid high and preloads na/nb.
  task automatic run_op(input int mode, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int wcnt,
                        input bit hold, input logic [31:0] na, input logic [31:0] nb);
    int edc [2];
    bit eill [2];
    logic [31:0] erd [2];
    bit seen [2];
    int done_it [2];
    int vcnt [2];
    logic [31:0] rrd [2];
    logic rwr [2];
    logic rill [2];
    for (int d = 0; d < 2; d++) begin
      int vl, vw, lim;
      vl  = (d == 1 && mode == 1) ? 0 : lat;
      vw  = (d == 1 && mode == 1) ? 0 : wcnt;
      lim = vw + T;
      if (vl != 0 && vl <= lim) begin
        edc[d] = vl; eill[d] = 1'b0;
        erd[d] = (d == 0 && mode == 1) ? DIV_VAL : a * b;
      end else begin
        edc[d] = lim; eill[d] = 1'b1; erd[d] = '0;
      end
      seen[d] = 1'b0; done_it[d] = 0; vcnt[d] = 0;
      rrd[d] = '0; rwr[d] = 1'b0; rill[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("idle_ready[%0d]", d), 32'(o_ready[d]), 32'd1);
      chk($sformatf("idle_pvalid[%0d]", d), 32'(o_valid[d]), 32'd0);
      chk($sformatf("idle_done[%0d]", d), 32'(o_done[d]), 32'd0);
    end
    chk("idle_wr_cleared", 32'(o_wr[0]), 32'd0);
    chk("idle_rd_held", o_rd[0], prev_rd);
    core_valid = 1'b1; core_insn = insn; core_rs1 = a; core_rs2 = b;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin core_rs1 = na; core_rs2 = nb; end
        else core_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("pcpi_insn[%0d]", d), o_insn[d], insn);
          chk($sformatf("pcpi_rs1[%0d]", d), o_rs1[d], a);
          chk($sformatf("pcpi_rs2[%0d]", d), o_rs2[d], b);
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (!seen[d]) begin
          if (o_done[d]) begin
            seen[d] = 1'b1; done_it[d] = c;
            rrd[d] = o_rd[d]; rwr[d] = o_wr[d]; rill[d] = o_ill[d];
          end else if (o_valid[d]) vcnt[d]++;
        end
      end
      if (seen[0] && seen[1]) break;
      mul_ready = (mode != 1) && (c == lat);
      mul_wr    = mul_ready;
      mul_rd    = o_rs1[0] * o_rs2[0];
      mul_wait  = (mode != 1) && (c <= wcnt);
      div_ready = (mode != 0) && (c == lat);
      div_wr    = div_ready;
      div_rd    = (mode == 2) ? 32'd2 : DIV_VAL;
      div_wait  = (mode != 0) && (c <= wcnt);
    end
    mul_ready = 1'b0; mul_wait = 1'b0; mul_wr = 1'b0;
    div_ready = 1'b0; div_wait = 1'b0; div_wr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("done_seen[%0d]", d), 32'(seen[d]), 32'd1);
      chk($sformatf("done_cycle[%0d]", d), 32'(done_it[d]), 32'(edc[d] + 1));
      chk($sformatf("pvalid_cycles[%0d]", d), 32'(vcnt[d]), 32'(edc[d]));
      chk($sformatf("illegal[%0d]", d), 32'(rill[d]), 32'(eill[d]));
      chk($sformatf("wr[%0d]", d), 32'(rwr[d]), 32'(!eill[d]));
      chk($sformatf("rd[%0d]", d), rrd[d], erd[d]);
    end
    prev_rd = erd[0];
    $display("op mode=%0d insn=%h a=%h b=%h lat=%0d wait=%0d -> done@%0d rd=%h ill=%0d | nodiv done@%0d rd=%h ill=%0d",
             mode, insn, a, b, lat, wcnt, done_it[0], rrd[0], rill[0], done_it[1], rrd[1], rill[1]);
  endtask

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready[%0d]", d), 32'(o_ready[d]), 32'd1);
      chk($sformatf("rst_pvalid[%0d]", d), 32'(o_valid[d]), 32'd0);
      chk($sformatf("rst_done[%0d]", d), 32'(o_done[d]), 32'd0);
      chk($sformatf("rst_wr[%0d]", d), 32'(o_wr[d]), 32'd0);
      chk($sformatf("rst_ill[%0d]", d), 32'(o_ill[d]), 32'd0);
      chk($sformatf("rst_rd[%0d]", d), o_rd[d], 32'd0);
      chk($sformatf("rst_pinsn[%0d]", d), o_insn[d] | o_rs1[d] | o_rs2[d], 32'd0);
    end
    $display("reset state checked");

    run_op(0, 32'h02C58533, 32'd7, 32'd6, 3, 2, 1'b0, '0, '0);     // MUL 7*6
    run_op(0, 32'h0000000B, 32'd1, 32'd2, 0, 0, 1'b0, '0, '0);     // unclaimed
    run_op(1, 32'h02C5C533, 32'd9, 32'd4, 101, 100, 1'b0, '0, '0); // long div wait
    run_op(2, 32'h02C58533, 32'd1, 32'd1, 2, 0, 1'b0, '0, '0);     // both ready
    run_op(0, 32'h02C58533, 32'd1, 32'd1, T, 0, 1'b0, '0, '0);     // ready on timeout cycle
    run_op(0, 32'h02C58533, 32'd5, 32'd5, 0, 5, 1'b0, '0, '0);     // wait released

    // Abort an op with a one-cycle reset while in ISSUE.
    @(negedge clk);
    core_valid = 1'b1; core_insn = 32'h0000000B; core_rs1 = 32'd3; core_rs2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    core_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_pvalid", 32'(o_valid[0]), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_pvalid", 32'(o_valid[0]), 32'd0);
    chk("abort_ready", 32'(o_ready[0]), 32'd1);
    chk("abort_done", 32'(o_done[0]), 32'd0);
    ndone = 0;
    for (int c = 0; c < T + 4; c++) begin
      @(negedge clk);
      if (o_done[0] || o_done[1]) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    prev_rd = '0;
    $display("reset abort checked, stray done=%0d", ndone);
    run_op(0, 32'h02C58533, 32'd3, 32'd5, 4, 0, 1'b0, '0, '0);     // MUL 3*5

    // Back-to-back with core_valid held high.
    run_op(0, 32'h02C58533, 32'd7, 32'd6, 1, 0, 1'b1, 32'd3, 32'd5);
    run_op(0, 32'h02C58533, 32'd3, 32'd5, 1, 0, 1'b0, '0, '0);

    for (int i = 0; i < 10; i++) begin
      int lat, wcnt;
      lat  = $urandom_range(0, 30);
      wcnt = (lat == 0) ? $urandom_range(0, 4)
                        : (($urandom_range(0, 1) == 1) ? $urandom_range(0, lat - 1) : 0);
      run_op(0, 32'h02C58533, $urandom, $urandom, lat, wcnt, 1'b0, '0, '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
